// File: rtl/mem_port_pkg.sv
// Shared types and constants for the core-to-memory port controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DONE,
        ERR
    } mport_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mport_req_t;

    localparam int unsigned MPORT_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_timer.sv
// Bus-wait watchdog: counts cycles spent waiting on the bus and flags expiry.
// Latency: expired is combinational on the count; the count updates every clk edge.
// Backpressure: none; it only observes the controller's wait states.
module mem_port_timer
    import mem_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MPORT_DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    // Wait counter: cleared when a request is issued, advanced while waiting.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

    // ">=" so a load accepted on the very last cycle still aborts in RESP
    // instead of letting the counter run past the limit.
    assign expired = en && (cnt >= LIMIT);

endmodule

// File: rtl/mem_port_ctrl.sv
// Mem-stage port controller: turns a held core request into one bus transaction.
// Latency: store 2 stall cycles, load 3 stall cycles minimum; core_done the next cycle.
// Backpressure: holds stall high until bus_ready (and bus_rvalid for loads); optional timeout via MEM_PORT_TIMEOUT_EN.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MPORT_DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [3:0]  core_mask,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        core_done,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [3:0]  bus_mask,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    mport_state_t state, state_nxt;
    mport_req_t   bus_req_q;
    logic         bus_valid_q;
    logic [31:0]  rdata_q;
    logic         start;
    logic         tmo;

    assign start = (state == IDLE) && core_req && !flush;

`ifdef MEM_PORT_TIMEOUT_EN
    logic tmr_en;
    assign tmr_en = (state == REQ) || (state == RESP);

    mem_port_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .arst_n  (arst_n),
        .clr     (start),
        .en      (tmr_en),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a completed handshake wins over a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ: begin
                if (bus_ready)  state_nxt = bus_req_q.we ? DONE : RESP;
                else if (tmo)   state_nxt = ERR;
            end
            RESP: begin
                if (bus_rvalid) state_nxt = DONE;
                else if (tmo)   state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Core-side outputs; stall is gated by reset so it reads 0 while held in reset.
    always_comb begin
        stall     = 1'b0;
        core_done = 1'b0;
        core_err  = 1'b0;
        case (state)
            IDLE:      stall = arst_n && core_req && !flush;
            REQ, RESP: stall = 1'b1;
            DONE:      core_done = 1'b1;
`ifdef MEM_PORT_TIMEOUT_EN
            ERR:       core_err = 1'b1;
`endif
            default: ;
        endcase
    end

    // Bus request registers and load-data capture.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bus_req_q   <= '0;
            bus_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (start) begin
                bus_req_q   <= '{we: core_we, mask: core_mask, addr: core_addr, wdata: core_wdata};
                bus_valid_q <= 1'b1;
            end else if (state == REQ && state_nxt != REQ) begin
                bus_valid_q <= 1'b0;
            end
            if (state == RESP && bus_rvalid) begin
                rdata_q <= bus_rdata;
            end else if (state_nxt == ERR) begin
                rdata_q <= '0;
            end
        end
    end

    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_req_q.we;
    assign bus_mask   = bus_req_q.mask;
    assign bus_addr   = bus_req_q.addr;
    assign bus_wdata  = bus_req_q.wdata;
    assign core_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a transaction-level scoreboard model.
// Latency: n/a.
// Backpressure: a reactive bus responder supplies programmable ready/rvalid delays.
module tb_mem_port_ctrl;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          tmo;
    } item_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        core_req, core_we, flush;
    logic [3:0]  core_mask;
    logic [31:0] core_addr, core_wdata;
    logic        stall, core_done, core_err;
    logic [31:0] core_rdata;
    logic        bus_valid, bus_we;
    logic [3:0]  bus_mask;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    item_t       exp_q[$];
    logic [31:0] mrdata = 32'h0;

    int          cfg_w  = 0;
    int          cfg_r  = 1;
    logic [31:0] cfg_rd = 32'h0;
    logic        extra_rv = 1'b0;
    int          vcnt = 0;
    int          age  = -1;

    mem_port_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_mask  (core_mask),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .flush      (flush),
        .stall      (stall),
        .core_done  (core_done),
        .core_rdata (core_rdata),
        .core_err   (core_err),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_mask   (bus_mask),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Bus responder: ready after cfg_w wait cycles, load data cfg_r cycles after acceptance.
    always @(posedge clk) begin
        bit rv, rdy;
        #2;
        rv = 1'b0;
        if (age >= 0) begin
            age++;
            if (age == cfg_r) begin
                rv  = 1'b1;
                age = -1;
            end
        end
        if (bus_valid && arst_n) begin
            rdy = (vcnt == cfg_w);
            vcnt++;
            if (rdy && !bus_we) age = 0;
        end else begin
            rdy  = 1'b0;
            vcnt = 0;
        end
        bus_ready  = rdy;
        bus_rvalid = rv | extra_rv;
        bus_rdata  = rv ? cfg_rd : (extra_rv ? 32'hBAD0BAD0 : 32'h0);
    end

    // Scoreboard compare: every cycle out of reset.
    always @(negedge clk) begin
        if (arst_n) begin
            if (exp_q.size() == 0) begin
                chk("bus_valid_idle", {31'd0, bus_valid}, 32'd0);
            end else if (bus_valid) begin
                chk("bus_we",    {31'd0, bus_we}, {31'd0, exp_q[0].we});
                chk("bus_mask",  {28'd0, bus_mask}, {28'd0, exp_q[0].mask});
                chk("bus_addr",  bus_addr, exp_q[0].addr);
                chk("bus_wdata", bus_wdata, exp_q[0].wdata);
            end
            if (core_done || core_err) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_completion", {30'd0, core_done, core_err}, 32'd0);
                end else begin
                    item_t       h;
                    logic [31:0] e;
                    h = exp_q.pop_front();
                    e = h.tmo ? 32'h0 : (h.we ? mrdata : h.rd);
                    chk("core_done_kind", {31'd0, core_done}, {31'd0, !h.tmo});
                    chk("core_err_kind",  {31'd0, core_err},  {31'd0, h.tmo});
                    chk("rdata_at_done",  core_rdata, e);
                    chk("stall_at_done",  {31'd0, stall}, 32'd0);
                    mrdata = e;
                end
            end else begin
                chk("rdata_hold", core_rdata, mrdata);
            end
        end
    end

    // One transaction from the core side; starts and ends at posedge+1.
    task automatic txn(input item_t it, input int w, input int r, input bit fl_req,
                       output int n_stall, output int n_done, output int n_vrise,
                       output int t_done, output int t_vrise, output logic end_bv);
        cfg_w  = w;
        cfg_r  = r;
        cfg_rd = it.rd;
        exp_q.push_back(it);
        core_req = 1'b1; core_we = it.we; core_mask = it.mask;
        core_addr = it.addr; core_wdata = it.wdata; flush = 1'b0;
        n_stall = 0; n_done = -1; n_vrise = -1; t_done = -1; t_vrise = -1; end_bv = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (bus_valid && n_vrise < 0) begin
                n_vrise = n;
                t_vrise = cyc;
            end
            if (core_done || core_err) begin
                n_done = n;
                t_done = cyc;
                end_bv = bus_valid;
            end
            @(posedge clk);
            #1;
            if (fl_req) flush = 1'b1;
            if (n_done >= 0) break;
        end
        core_req = 1'b0;
        flush    = 1'b0;
        if (n_done < 0) begin
            total++;
            bad++;
            $display("FAIL txn_bound: no completion for addr 0x%08h within 200 cycles", it.addr);
        end
    endtask

    task automatic reset_now();
        arst_n   = 1'b0;
        exp_q.delete();
        mrdata   = 32'h0;
        core_req = 1'b0;
        flush    = 1'b0;
        extra_rv = 1'b0;
        cfg_w    = 0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"},     {31'd0, stall}, 32'd0);
        chk({tag, "_core_done"}, {31'd0, core_done}, 32'd0);
        chk({tag, "_core_err"},  {31'd0, core_err}, 32'd0);
        chk({tag, "_rdata"},     core_rdata, 32'd0);
        chk({tag, "_bus_valid"}, {31'd0, bus_valid}, 32'd0);
        chk({tag, "_bus_we"},    {31'd0, bus_we}, 32'd0);
        chk({tag, "_bus_mask"},  {28'd0, bus_mask}, 32'd0);
        chk({tag, "_bus_addr"},  bus_addr, 32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    endtask

    initial begin
        item_t it;
        int    ns, nd, nv, td, tv, td1, cnt_s, cnt_v, cnt_d;
        logic  ebv;

        arst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; flush = 1'b0;
        core_mask = 4'h0; core_addr = 32'h0; core_wdata = 32'h0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #3;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store, accepted at first valid.
        it = '{we: 1'b1, mask: 4'hF, addr: 32'h100, wdata: 32'hDEADBEEF, rd: 32'h0, tmo: 1'b0};
        txn(it, 0, 1, 1'b0, ns, nd, nv, td, tv, ebv);
        chk("store_stall_cycles", ns, 2);
        chk("store_done_cycle", nd, 2);
        chk("store_valid_rise", nv, 1);

        // Load with 3 ready-wait cycles and response 2 cycles after acceptance.
        it = '{we: 1'b0, mask: 4'hF, addr: 32'h200, wdata: 32'h0, rd: 32'h12345678, tmo: 1'b0};
        txn(it, 3, 2, 1'b0, ns, nd, nv, td, tv, ebv);
        chk("load_stall_cycles", ns, 7);
        chk("load_done_cycle", nd, 7);
        chk("load_rdata_literal", core_rdata, 32'h12345678);

        // Minimum-latency load.
        it = '{we: 1'b0, mask: 4'h3, addr: 32'h204, wdata: 32'h0, rd: 32'hCAFEF00D, tmo: 1'b0};
        txn(it, 0, 1, 1'b0, ns, nd, nv, td, tv, ebv);
        chk("minload_stall_cycles", ns, 3);
        chk("minload_done_cycle", nd, 3);

        // Store leaves load data untouched.
        it = '{we: 1'b1, mask: 4'h1, addr: 32'h300, wdata: 32'h11223344, rd: 32'h0, tmo: 1'b0};
        txn(it, 1, 1, 1'b0, ns, nd, nv, td, tv, ebv);
        chk("store_w1_stall_cycles", ns, 3);
        chk("store_keeps_rdata", core_rdata, 32'hCAFEF00D);

        // Stray response while idle is ignored.
        extra_rv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        extra_rv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stray_rvalid_rdata", core_rdata, 32'hCAFEF00D);

        // Flush with request in IDLE drops it.
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h3F0; flush = 1'b1;
        cnt_s = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall) cnt_s++;
            @(posedge clk);
            #1;
        end
        core_req = 1'b0; flush = 1'b0;
        chk("flush_idle_stall", cnt_s, 0);

        // Flush while waiting on the bus is ignored.
        it = '{we: 1'b1, mask: 4'hC, addr: 32'h400, wdata: 32'hA5A5A5A5, rd: 32'h0, tmo: 1'b0};
        txn(it, 2, 1, 1'b1, ns, nd, nv, td, tv, ebv);
        chk("flush_req_stall_cycles", ns, 4);
        chk("flush_req_done_cycle", nd, 4);

        // Back-to-back store then load.
        it = '{we: 1'b1, mask: 4'hF, addr: 32'h500, wdata: 32'h01020304, rd: 32'h0, tmo: 1'b0};
        txn(it, 0, 1, 1'b0, ns, nd, nv, td1, tv, ebv);
        it = '{we: 1'b0, mask: 4'hF, addr: 32'h504, wdata: 32'h0, rd: 32'h0BADF00D, tmo: 1'b0};
        txn(it, 0, 1, 1'b0, ns, nd, nv, td, tv, ebv);
        chk("b2b_valid_after_done", tv - td1, 2);
        chk("b2b_load_done_cycle", nd, 3);

`ifdef MEM_PORT_TIMEOUT_EN
        // Bus never ready: abort after TMO wait cycles.
        it = '{we: 1'b0, mask: 4'hF, addr: 32'h600, wdata: 32'h0, rd: 32'h0, tmo: 1'b1};
        txn(it, 100000, 1, 1'b0, ns, nd, nv, td, tv, ebv);
        chk("tmo_stall_cycles", ns, 5);
        chk("tmo_err_cycle", nd, 5);
        chk("tmo_bus_valid_low", {31'd0, ebv}, 32'd0);
        chk("tmo_rdata_zero", core_rdata, 32'h0);
        cfg_w = 0;
`else
        // Bus never ready: request waits indefinitely.
        it = '{we: 1'b0, mask: 4'hF, addr: 32'h600, wdata: 32'h0, rd: 32'h0, tmo: 1'b0};
        cfg_w = 100000;
        exp_q.push_back(it);
        core_req = 1'b1; core_we = 1'b0; core_mask = 4'hF; core_addr = 32'h600;
        cnt_s = 0; cnt_v = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall) cnt_s++;
            if (bus_valid) cnt_v++;
            @(posedge clk);
            #1;
        end
        chk("notmo_stall_100", cnt_s, 100);
        chk("notmo_valid_99", cnt_v, 99);
        reset_now();
`endif

        // Reset in RESP abandons the load.
        it = '{we: 1'b0, mask: 4'hF, addr: 32'h700, wdata: 32'h0, rd: 32'h55AA55AA, tmo: 1'b0};
        cfg_w = 0; cfg_r = 5; cfg_rd = it.rd;
        exp_q.push_back(it);
        core_req = 1'b1; core_we = 1'b0; core_mask = 4'hF; core_addr = 32'h700;
        repeat (3) @(negedge clk);
        chk("resp_stall_before_reset", {31'd0, stall}, 32'd1);
        #2;
        arst_n = 1'b0;
        exp_q.delete();
        mrdata = 32'h0;
        #1;
        chk_reset_outputs("async_reset");
        core_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        cnt_d = 0; cnt_v = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (core_done) cnt_d++;
            if (bus_valid) cnt_v++;
        end
        chk("post_reset_no_done", cnt_d, 0);
        chk("post_reset_no_valid", cnt_v, 0);
        @(posedge clk);
        #1;

        // Recovery after reset.
        it = '{we: 1'b1, mask: 4'h6, addr: 32'h800, wdata: 32'hFEEDFACE, rd: 32'h0, tmo: 1'b0};
        txn(it, 0, 1, 1'b0, ns, nd, nv, td, tv, ebv);
        chk("recover_stall_cycles", ns, 2);
        chk("recover_done_cycle", nd, 2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
